// File: rtl/mux21_arbiter.sv
// Round-robin sequencer for a shared 2:1 mux: bounded-hold arbitration drives the
// select line and one-hot grants, and registers the granted data onto Y with VALID.
module mux21_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             VALID
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
  localparam logic          HOLD_EN  = (MAX_HOLD > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_s;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_nxt;
  logic             r_valid;
  logic             w_valid_nxt;

  // Arbitration: next state, hold counter and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;

    case (r_state)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          w_state_nxt = r_last ? ST_G0 : ST_G1;
        end else if (REQ0) begin
          w_state_nxt = ST_G0;
        end else if (REQ1) begin
          w_state_nxt = ST_G1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_G0: begin
        if (!REQ0) begin
          w_state_nxt = REQ1 ? ST_G1 : ST_IDLE;
        end else if (REQ1 && HOLD_EN && (r_cnt == CNT_MAX)) begin
          w_state_nxt = ST_G1;
        end else begin
          w_state_nxt = ST_G0;
        end
      end
      ST_G1: begin
        if (!REQ1) begin
          w_state_nxt = REQ0 ? ST_G0 : ST_IDLE;
        end else if (REQ0 && HOLD_EN && (r_cnt == CNT_MAX)) begin
          w_state_nxt = ST_G0;
        end else begin
          w_state_nxt = ST_G1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Entry into a grant restarts tenure at 1; holding saturates at MAX_HOLD.
    if (w_state_nxt == ST_IDLE) begin
      w_cnt_nxt = CNT_ZERO;
    end else if (w_state_nxt != r_state) begin
      w_cnt_nxt  = CNT_ONE;
      w_last_nxt = (w_state_nxt == ST_G1) ? 1'b1 : 1'b0;
    end else if (HOLD_EN && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Datapath: capture the data of the currently granted, still-requesting source.
  always_comb begin
    w_y_nxt     = r_y;
    w_valid_nxt = 1'b0;
    if ((r_state == ST_G0) && REQ0) begin
      w_y_nxt     = D0;
      w_valid_nxt = 1'b1;
    end else if ((r_state == ST_G1) && REQ1) begin
      w_y_nxt     = D1;
      w_valid_nxt = 1'b1;
    end else begin
      w_y_nxt     = r_y;
      w_valid_nxt = 1'b0;
    end
  end

  // State, counter, pointer and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_s     <= 1'b0;
      r_y     <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt0  <= (w_state_nxt == ST_G0) ? 1'b1 : 1'b0;
      r_gnt1  <= (w_state_nxt == ST_G1) ? 1'b1 : 1'b0;
      r_s     <= (w_state_nxt == ST_G1) ? 1'b1 : 1'b0;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign GNT0  = r_gnt0;
  assign GNT1  = r_gnt1;
  assign S     = r_s;
  assign Y     = r_y;
  assign VALID = r_valid;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Scoreboard bench for mux21_arbiter: a MAX_HOLD=4 and a MAX_HOLD=0 instance share
// stimulus; a reference model pushes expected outputs that are popped after each edge.
module tb_mux21_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ0 = 1'b0;
  logic       REQ1 = 1'b0;
  logic [7:0] D0 = 8'h00;
  logic [7:0] D1 = 8'h00;

  logic       gnt0_a, gnt1_a, s_a, valid_a;
  logic [7:0] y_a;
  logic       gnt0_b, gnt1_b, s_b, valid_b;
  logic [7:0] y_b;

  int n_pass   = 0;
  int n_checks = 0;

  mux21_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .S(s_a), .Y(y_a), .VALID(valid_a)
  );

  mux21_arbiter #(.WIDTH(8), .MAX_HOLD(0)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .S(s_b), .Y(y_b), .VALID(valid_b)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: st 0=idle 1=g0 2=g1, ten = unbounded tenure length.
  typedef struct {
    int         st;
    int         ten;
    bit         last;
    logic [7:0] y;
    bit         v;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t sb_q[$];
  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.ten = 0; m.last = 1'b1; m.y = 8'h00; m.v = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int hold, bit r0, bit r1,
                                    logic [7:0] d0, logic [7:0] d1);
    mdl_t n = m;
    bit   mine, other;
    if (m.st == 1 && r0) begin n.y = d0; n.v = 1'b1; end
    else if (m.st == 2 && r1) begin n.y = d1; n.v = 1'b1; end
    else n.v = 1'b0;
    if (m.st == 0) begin
      if (r0 && r1) n.st = m.last ? 1 : 2;
      else n.st = r0 ? 1 : (r1 ? 2 : 0);
    end else begin
      mine  = (m.st == 1) ? r0 : r1;
      other = (m.st == 1) ? r1 : r0;
      if (!mine) n.st = other ? 3 - m.st : 0;
      else if (other && hold > 0 && m.ten >= hold) n.st = 3 - m.st;
      else n.st = m.st;
    end
    if (n.st == 0) n.ten = 0;
    else if (n.st != m.st) begin n.ten = 1; n.last = (n.st == 2); end
    else n.ten = m.ten + 1;
    return n;
  endfunction

  task automatic drive(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
    exp_t e;
    REQ0 = r0; REQ1 = r1; D0 = d0; D1 = d1;
    ma = mdl_step(ma, 4, r0, r1, d0, d1);
    mb = mdl_step(mb, 0, r0, r1, d0, d1);
    e.a = ma; e.b = mb;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("gnt0_a", 32'(gnt0_a), 32'(e.a.st == 1));
      check_eq("gnt1_a", 32'(gnt1_a), 32'(e.a.st == 2));
      check_eq("valid_a", 32'(valid_a), 32'(e.a.v));
      check_eq("y_a", 32'(y_a), 32'(e.a.y));
      check_eq("gnt0_b", 32'(gnt0_b), 32'(e.b.st == 1));
      check_eq("gnt1_b", 32'(gnt1_b), 32'(e.b.st == 2));
      check_eq("valid_b", 32'(valid_b), 32'(e.b.v));
      check_eq("y_b", 32'(y_b), 32'(e.b.y));
    end
  endtask

  task automatic cycle(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
    drive(r0, r1, d0, d1);
    settle();
  endtask

  task automatic do_reset();
    REQ0 = 1'b0; REQ1 = 1'b0;
    RST_N = 1'b0;
    ma = mdl_reset(); mb = mdl_reset();
    sb_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    check_eq("rst_gnt0", 32'(gnt0_a), 32'd0);
    check_eq("rst_gnt1", 32'(gnt1_a), 32'd0);
    check_eq("rst_s", 32'(s_a), 32'd0);
    check_eq("rst_y", 32'(y_a), 32'd0);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    RST_N = 1'b1;
  endtask

  // Per-cycle invariants; previous-cycle grant and data captured at the edge.
  logic [7:0] pd0, pd1;
  logic       pg0_a, pg0_b;
  always @(posedge CLK) begin
    pd0   <= D0;
    pd1   <= D1;
    pg0_a <= gnt0_a;
    pg0_b <= gnt0_b;
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      check_eq("excl_a", 32'(gnt0_a & gnt1_a), 32'd0);
      check_eq("excl_b", 32'(gnt0_b & gnt1_b), 32'd0);
      check_eq("s_eq_a", 32'(s_a), 32'(gnt1_a));
      check_eq("s_eq_b", 32'(s_b), 32'(gnt1_b));
      if (valid_a) check_eq("vdata_a", 32'(y_a), 32'(pg0_a ? pd0 : pd1));
      if (valid_b) check_eq("vdata_b", 32'(y_b), 32'(pg0_b ? pd0 : pd1));
    end
  end

  initial begin
    ma = mdl_reset(); mb = mdl_reset();
    do_reset();

    // Single requester: grant one edge after request, data one edge after grant.
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'hA5, 8'h00);
    check_eq("t1_gnt0", 32'(gnt0_a), 32'd1);
    check_eq("t1_s", 32'(s_a), 32'd0);
    check_eq("t1_valid0", 32'(valid_a), 32'd0);
    cycle(1'b1, 1'b0, 8'hA5, 8'h00);
    check_eq("t1_y", 32'(y_a), 32'hA5);
    check_eq("t1_valid1", 32'(valid_a), 32'd1);
    check_eq("t1_gnt1", 32'(gnt1_a), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);

    // Contention: tie to requester 0, forced handoff after four grant cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'h11, 8'h3C);
      check_eq("t2_hold0", 32'(gnt0_a), 32'd1);
    end
    cycle(1'b1, 1'b1, 8'h11, 8'h3C);
    check_eq("t2_gnt1", 32'(gnt1_a), 32'd1);
    check_eq("t2_s1", 32'(s_a), 32'd1);
    check_eq("t2_b_hold", 32'(gnt0_b), 32'd1);
    cycle(1'b1, 1'b1, 8'h11, 8'h3C);
    check_eq("t2_y", 32'(y_a), 32'h3C);
    cycle(1'b1, 1'b1, 8'h11, 8'h3C);
    cycle(1'b1, 1'b1, 8'h11, 8'h3C);
    check_eq("t2_still1", 32'(gnt1_a), 32'd1);
    cycle(1'b1, 1'b1, 8'h11, 8'h3C);
    check_eq("t2_back0", 32'(gnt0_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    end

    // Requester 0 drops with requester 1 waiting: direct handoff, one VALID gap.
    do_reset();
    cycle(1'b1, 1'b0, 8'h44, 8'h00);
    cycle(1'b1, 1'b1, 8'h55, 8'hC3);
    cycle(1'b0, 1'b1, 8'h77, 8'hC3);
    check_eq("t3_gnt0", 32'(gnt0_a), 32'd0);
    check_eq("t3_gnt1", 32'(gnt1_a), 32'd1);
    check_eq("t3_gap", 32'(valid_a), 32'd0);
    cycle(1'b0, 1'b1, 8'h77, 8'hC3);
    check_eq("t3_valid", 32'(valid_a), 32'd1);
    check_eq("t3_y", 32'(y_a), 32'hC3);

    // No forced handoff when MAX_HOLD is zero.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 8'hF0);
      check_eq("t4_b_hold", 32'(gnt0_b), 32'd1);
    end
    cycle(1'b0, 1'b1, 8'h00, 8'hF0);
    check_eq("t4_b_gnt1", 32'(gnt1_b), 32'd1);

    // Asynchronous reset pulse between edges while granted.
    do_reset();
    cycle(1'b1, 1'b0, 8'h5A, 8'h00);
    cycle(1'b1, 1'b0, 8'h5A, 8'h00);
    REQ1 = 1'b1;
    D1   = 8'h69;
    #1 RST_N = 1'b0;
    #1;
    check_eq("t5_gnt0", 32'(gnt0_a), 32'd0);
    check_eq("t5_gnt1", 32'(gnt1_a), 32'd0);
    check_eq("t5_valid", 32'(valid_a), 32'd0);
    check_eq("t5_y", 32'(y_a), 32'd0);
    #2 RST_N = 1'b1;
    ma = mdl_reset(); mb = mdl_reset();
    sb_q.delete();
    cycle(1'b1, 1'b1, 8'h5A, 8'h69);
    check_eq("t5_winner0", 32'(gnt0_a), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
- Sequencing controller for the shared 2:1 multiplexer datapath. Two requesters compete for the mux output.
- Round-robin arbitration with a bounded hold time drives the select line S, issues one-hot grants and registers the selected data onto Y with a VALID qualifier.
- Sits between two data producers and a single downstream consumer. Replaces free-running select stimulus with a handshaked, fair sequencer.

Parameters:
- WIDTH, 8: data width of D0, D1 and Y.
- MAX_HOLD, 4: maximum consecutive grant cycles while the other requester waits. 0 means no forced handoff.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ0  input  1  requester 0 request; level, held while the resource is wanted.
- REQ1  input  1  requester 1 request.
- D0  input  WIDTH  requester 0 data.
- D1  input  WIDTH  requester 1 data.
- GNT0  output  1  registered grant to requester 0.
- GNT1  output  1  registered grant to requester 1.
- S  output  1  mux select: 1 in G1, otherwise 0.
- Y  output  WIDTH  registered mux output.
- VALID  output  1  Y carries data from a granted, requesting source.

Behaviour:
- Reset (RST_N=0, immediate, independent of CLK):
  - state=IDLE, GNT0=GNT1=0, S=0, Y=0, VALID=0, cnt=0, last=1.
  - last=1 means requester 0 wins the first tie.
- States: IDLE, G0, G1. GNT0=(state==G0), GNT1=(state==G1). Grants are never both high.
- IDLE:
  - REQ0 only -> G0. REQ1 only -> G1. Neither -> IDLE.
  - Both -> grant the index != last.
- G0 (G1 is symmetric):
  - REQ0=0 -> G1 if REQ1=1, else IDLE.
  - REQ0=1, REQ1=1, MAX_HOLD>0, GNT0 already high for MAX_HOLD cycles -> G1 (forced handoff).
  - Otherwise stay in G0.
- Direct G0<->G1 handoff has no idle cycle: GNT0 falls and GNT1 rises on the same edge.
- last is updated to the granted index on every entry into G0 or G1.
- cnt:
  - Counts grant cycles. Cleared to 1 on the edge entering a grant state, increments each edge the state holds.
  - Saturates at MAX_HOLD. Width clog2(MAX_HOLD+1), minimum 1 bit.
  - Forced handoff triggers when cnt==MAX_HOLD and the other request is high.
  - Cleared to 0 in IDLE.
- Grant latency: request sampled at edge k -> GNT high after edge k. Minimum one cycle from REQ rising to GNT.
- Data path, registered one cycle behind grant:
  - At each edge, state G0 and REQ0=1 -> Y<=D0, VALID<=1.
  - State G1 and REQ1=1 -> Y<=D1, VALID<=1.
  - Else VALID<=0 and Y holds its value.
- Request dropped in the same cycle it is granted: no VALID beat for that source. Transition follows the G0/G1 rules.
- Mid-operation reset: all outputs go to reset values asynchronously. After release, the first grant follows IDLE rules with last=1.
- Reset release is synchronised externally by the system. The block samples no inputs while RST_N=0.

Test Plan:
- Reset, then REQ0=1 at cycle 2 with D0=8'hA5 -> GNT0=1 from cycle 3, S=0, Y=8'hA5 with VALID=1 from cycle 4. GNT1 stays 0.
- REQ0=REQ1=1 from IDLE after reset -> GNT0 first. After 4 grant cycles, forced handoff: GNT1=1, S=1, Y=D1 (8'h3C). After 4 more cycles, back to GNT0.
- Requester 0 granted, REQ0 drops while REQ1=1 -> next edge GNT0=0, GNT1=1 with no idle cycle. VALID=0 for exactly one cycle, then Y=D1.
- MAX_HOLD=0 build, both requesting -> GNT0 held indefinitely. GNT1 only after REQ0 drops.
- Async reset pulse mid-grant (RST_N low 3 ns between edges) -> GNT0, GNT1, VALID, Y go to 0 immediately. After release with REQ0=REQ1=1, requester 0 wins.
- Continuous checker on every cycle: never GNT0&GNT1; S==GNT1; VALID implies Y equals the granted source's data from the previous cycle.
